ones_gen: RTL and testbench
===========================

ONES_GEN -- requirements
Module: ones_gen

Interface
REQ-001 Parameter: n, default 6, word-size exponent; word length W = 2**(n+1)-1 bits (127 at default).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 Port: in_count  input  n+1  number of ones to emit in the word, range 0..W.
REQ-005 Port: in_valid  input  1  in_count valid.
REQ-006 Port: in_ready  output  1  block can accept in_count.
REQ-007 Port: out_bit  output  1  current serial word bit, word index 0 first.
REQ-008 Port: out_valid  output  1  out_bit valid.
REQ-009 Port: out_ready  input  1  sink accepts out_bit.
REQ-010 Port: out_last  output  1  out_bit is word index W-1.
REQ-011 Port: remaining  output  n+1  ones of current word not yet accepted by sink.

Function
REQ-012 The block SHALL be the inverse of the team's ones counter: from a count, emit a W-bit serial word containing exactly in_count ones.
REQ-013 States SHALL be IDLE and EMIT; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in EMIT.
REQ-014 Input accept = in_valid & in_ready; on accept latch in_count, set idx=0, acc=0, remaining=in_count, go EMIT.
REQ-015 Output transfer = out_valid & out_ready; on transfer idx SHALL increment by 1 and remaining SHALL decrement by out_bit.
REQ-016 With out_ready low, out_bit, out_last, idx, acc and remaining SHALL hold.
REQ-017 out_last SHALL be 1 exactly when EMIT and idx == W-1.
REQ-018 Transfer with out_last SHALL return to IDLE next cycle; next accept no earlier than the cycle after (one bubble between words).
REQ-019 Minimum latency: accept at edge k, first out_valid visible after edge k; W transfers minimum per word.
REQ-020 Default (leading) mode: out_bit = (idx < latched count); ones occupy indices 0..count-1.
REQ-021 in_count = 0 SHALL emit W zeros; in_count = W SHALL emit W ones; both still take W transfers.
REQ-022 in_valid while not in_ready SHALL be ignored; latched count SHALL not change during EMIT.
REQ-023 remaining SHALL equal 0 after the out_last transfer in every mode.
REQ-024 idx SHALL be n+1 bits; acc n+2 bits; no arithmetic SHALL wrap within a word.

Reset
REQ-025 rst_n low at a clk edge SHALL force IDLE, idx=0, acc=0, remaining=0, latched count=0.
REQ-026 Reset outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0, remaining=0.
REQ-027 Reset mid-word SHALL abandon the word; no further bits of it emitted; next accept produces a fresh word.
REQ-028 Reset SHALL take priority over simultaneous accept or transfer.

Configuration
REQ-029 Macro ONES_GEN_SPREAD_EN defined: spread mode; out_bit = (acc + count >= W); on transfer acc <= acc + count - (out_bit ? W : 0).
REQ-030 Macro undefined: leading mode per REQ-020; acc register absent or constant 0.
REQ-031 In both modes total ones per word SHALL equal latched count; all other behaviour identical.

Verification
REQ-032 Reset, then in_count=5 accepted, out_ready=1 -> leading: bits 0..4 =1, 5..126 =0, out_last at transfer 127, remaining 5->0.
REQ-033 in_count=0 then in_count=127 -> 127 zeros then 127 ones; in_ready low during each word, one bubble between.
REQ-034 in_count=64, out_ready toggled randomly -> outputs hold while stalled; exactly 64 ones, order unchanged vs out_ready=1.
REQ-035 ONES_GEN_SPREAD_EN, in_count=1 -> single 1 at index 126; in_count=63 -> 63 ones, no two adjacent, total checked.
REQ-036 rst_n low at transfer 40 of word count=100 -> next cycle IDLE, remaining=0, out_valid=0; next word count=3 correct.
REQ-037 Loopback: serialized word collected into W-bit vector feeds the ones counter -> count equals in_count for all 0..127.

Source files
------------

// File: rtl/ones_gen.sv
// ones_gen -- serial word generator, the inverse of a ones counter.
//
// A count accepted on the input handshake produces one W-bit serial word,
// W = 2**(n+1)-1, which contains exactly that many ones. The word is sent
// index 0 first over a valid/ready handshake.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_count   number of ones for the next word (0..W)
//   in_valid   in_count is valid
//   in_ready   block is idle and can accept a count
//   out_bit    current serial bit
//   out_valid  out_bit is valid (high only while a word is being emitted)
//   out_ready  sink accepts out_bit
//   out_last   out_bit is the final bit (index W-1) of the word
//   remaining  ones of the current word not yet accepted by the sink
//
// Build option:
//   ONES_GEN_SPREAD_EN  defined: ones are spread evenly over the word using
//                       an error accumulator (acc).
//                       undefined: ones occupy the leading indices
//                       0..count-1 and no accumulator exists.

module ones_gen #(
  parameter int n = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n:0]   in_count,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [n:0]   remaining
);

  localparam int         IW       = n + 1;
  localparam int         W        = 2 ** IW - 1;
  localparam logic [n:0] LAST_IDX = IW'(W - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [n:0] idx_reg;
  logic [n:0] count_reg;
  logic [n:0] remaining_reg;
  logic       bit_raw;
  logic       accept;
  logic       xfer;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = EMIT;
      EMIT:    if (out_ready && (idx_reg == LAST_IDX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == EMIT);
    out_last  = (state_reg == EMIT) && (idx_reg == LAST_IDX);
    // Gated by state so the bit reads 0 whenever nothing is being emitted.
    out_bit   = (state_reg == EMIT) && bit_raw;
    remaining = remaining_reg;
  end

  // ---------------------------------------------------------- bit source
`ifdef ONES_GEN_SPREAD_EN
  // Bresenham-style accumulator: acc stays in [0, W), so acc + count never
  // exceeds 2W-1 and fits in n+2 bits. Over W steps acc returns to a value
  // below W, which forces exactly count ones per word.
  localparam logic [n+1:0] W_ACC = (IW + 1)'(W);

  logic [n+1:0] acc_reg;
  logic [n+1:0] acc_sum;
  logic [n+1:0] acc_next;

  always_comb begin
    acc_sum  = acc_reg + {1'b0, count_reg};
    bit_raw  = (acc_sum >= W_ACC);
    acc_next = bit_raw ? (acc_sum - W_ACC) : acc_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= '0;
    end else if (xfer) begin
      acc_reg <= acc_next;
    end
  end
`else
  // Leading ones: indices 0..count-1 carry a one.
  always_comb begin
    bit_raw = (idx_reg < count_reg);
  end
`endif

  // ------------------------------------------------------------ datapath
  // idx reaches W after the final transfer, which still fits in n+1 bits,
  // so the increment never wraps inside a word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
    end else if (accept) begin
      idx_reg       <= '0;
      count_reg     <= in_count;
      remaining_reg <= in_count;
    end else if (xfer) begin
      idx_reg       <= idx_reg + 1'b1;
      remaining_reg <= remaining_reg - {{n{1'b0}}, out_bit};
    end
  end

endmodule

// File: tb/tb_ones_gen.sv
module tb_ones_gen;

  localparam int N = 6;
  localparam int W = 127;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N:0]   in_count;
  logic         in_valid;
  logic         in_ready;
  logic         out_bit;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [N:0]   remaining;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] vec;
  logic [W-1:0] ref_vec;

  always #5 clk = ~clk;

  ones_gen #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_count  (in_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .remaining (remaining)
  );

  // Expected bit t of a word with c ones.
  // Spread: bit t is one when floor((t+1)*c/W) steps past floor(t*c/W).
  function automatic logic exp_bit(input int c, input int t);
`ifdef ONES_GEN_SPREAD_EN
    return (((t + 1) * c) / W) != ((t * c) / W);
`else
    return t < c;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends one count and collects the word. stall randomises out_ready,
  // noise drives in_valid with a different count while the word is emitted,
  // abort_at >= 0 asserts reset at that transfer and returns early.
  task automatic run_word(input int c, input bit stall, input bit noise,
                          input int abort_at, output logic [W-1:0] v);
    int   t;
    int   cyc;
    int   rem_exp;
    bit   stalled;
    logic held_bit;
    logic held_last;
    logic [N:0] held_rem;

    v = '0;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_wait", in_ready, 1'b1);

    in_count  = c[N:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = noise;
    in_count = noise ? 7'd7 : c[N:0];
    check("accept_out_valid", out_valid, 1'b1);
    check("accept_remaining", remaining, c);

    t = 0;
    cyc = 0;
    rem_exp = c;
    stalled = 1'b0;
    held_bit = 1'b0;
    held_last = 1'b0;
    held_rem = '0;
    while (t < W && cyc < 8 * W) begin
      check("emit_in_ready", in_ready, 1'b0);
      check("emit_out_valid", out_valid, 1'b1);
      if (stalled) begin
        check("hold_bit", out_bit, held_bit);
        check("hold_last", out_last, held_last);
        check("hold_remaining", remaining, held_rem);
      end
      check("bit", out_bit, exp_bit(c, t));
      check("last", out_last, (t == W - 1));
      check("remaining", remaining, rem_exp);

      if (t == abort_at) begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        $display("word count=%0d aborted at transfer %0d", c, t + 1);
        return;
      end

      out_ready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      in_valid  = noise && (t < W - 1);
      held_bit  = out_bit;
      held_last = out_last;
      held_rem  = remaining;
      stalled   = !out_ready;
      if (out_ready) begin
        v[t] = out_bit;
        if (exp_bit(c, t)) rem_exp--;
        t++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("word_complete", t, W);
    check("bubble_in_ready", in_ready, 1'b1);
    check("bubble_out_valid", out_valid, 1'b0);
    check("end_remaining", remaining, 0);
    check("end_last", out_last, 1'b0);
    $display("word count=%0d ones=%0d", c, $countones(v));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_count  = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_remaining", remaining, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Leading mode: bits 0..4 set.
    run_word(5, 1'b0, 1'b0, -1, vec);
    check("ones_5", $countones(vec), 5);
`ifndef ONES_GEN_SPREAD_EN
    ref_vec = 127'h1F;
    check("vec_5", vec, ref_vec);
`endif

    // Extremes back to back.
    run_word(0, 1'b0, 1'b0, -1, vec);
    check("vec_0", vec, 127'd0);
    run_word(127, 1'b0, 1'b0, -1, vec);
    ref_vec = '1;
    check("vec_127", vec, ref_vec);

    // Random stalls with in_valid noise during the word.
    run_word(64, 1'b1, 1'b1, -1, vec);
    check("ones_64_stall", $countones(vec), 64);
`ifndef ONES_GEN_SPREAD_EN
    ref_vec = {63'd0, {64{1'b1}}};
    check("vec_64_stall", vec, ref_vec);
`endif

`ifdef ONES_GEN_SPREAD_EN
    run_word(1, 1'b0, 1'b0, -1, vec);
    ref_vec = '0;
    ref_vec[126] = 1'b1;
    check("spread_1", vec, ref_vec);
    run_word(63, 1'b0, 1'b0, -1, vec);
    check("spread_63_ones", $countones(vec), 63);
    check("spread_63_adjacent", vec & (vec >> 1), 127'd0);
`endif

    // Reset at transfer 40 of a count=100 word.
    run_word(100, 1'b0, 1'b0, 39, vec);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_remaining", remaining, 0);
    check("abort_out_bit", out_bit, 1'b0);
    check("abort_out_last", out_last, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    run_word(3, 1'b0, 1'b0, -1, vec);
    check("after_abort_ones", $countones(vec), 3);
`ifndef ONES_GEN_SPREAD_EN
    ref_vec = 127'h7;
    check("after_abort_vec", vec, ref_vec);
`endif

    // Loopback through a ones count for every legal count.
    for (int c = 0; c <= W; c++) begin
      run_word(c, 1'b0, 1'b0, -1, vec);
      check("loopback_count", $countones(vec), c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
